// File: rtl/uart_stream_tx_if.sv
// Valid/ready word stream feeding the UART transmitter.
interface uart_stream_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_stream_tx.sv
// FIFO-backed UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// A word pushed into an empty FIFO while idle starts its start bit on the next edge.
// s_ready drops when the FIFO is full; queued frames go out back-to-back.
module uart_stream_tx #(
    parameter int CLOCK_FREQUENCY = 48_000_000,
    parameter int BAUDRATE        = 115_200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16,
    parameter int LEVEL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    uart_stream_tx_if.slave     s,
    output logic                tx,
    output logic                busy,
    output logic [LEVEL_W-1:0]  fifo_level
);
    localparam int DIVIDER = CLOCK_FREQUENCY / BAUDRATE;
    localparam int BAUD_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0]   level, level_n;
    logic                 full_q, push, pop, empty;
    logic [DATA_BITS-1:0] rd_data;

    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_n;
    logic [CNT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par_q, par_n, tx_q, tx_n, tick;

    assign s.s_ready  = !full_q;
    assign push       = s.s_valid && !full_q;
    assign empty      = (level == '0);
    assign rd_data    = mem[rd_ptr];
    assign fifo_level = level;
    assign tx         = tx_q;
    assign busy       = (state != S_IDLE);
    assign tick       = (baud_cnt == BAUD_W'(DIVIDER - 1));

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= s.s_data;
    end

    always_comb begin
        level_n = level;
        if (push && !pop)      level_n = level + 1'b1;
        else if (!push && pop) level_n = level - 1'b1;
    end

    // full is registered from the next level so s_ready falls on the edge that fills the FIFO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level  <= level_n;
            full_q <= (level_n == LEVEL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            par_q    <= par_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = tick ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        par_n   = par_q;
        tx_n    = tx_q;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = rd_data;
                    par_n   = (^rd_data) ^ (PARITY == 1);
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_n    = shreg[0];
                    sh_n    = shreg >> 1;
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            tx_n    = par_q;
                            state_n = S_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = S_STOP;
                        end
                    end else begin
                        tx_n  = shreg[0];
                        sh_n  = shreg >> 1;
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tx_n    = 1'b1;
                    bit_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                        bit_n = '0;
                        // chain straight into the next start bit when more words wait
                        if (!empty) begin
                            pop     = 1'b1;
                            sh_n    = rd_data;
                            par_n   = (^rd_data) ^ (PARITY == 1);
                            tx_n    = 1'b0;
                            state_n = S_START;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
